// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 dual-channel memory responder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } chan_state_t;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;
    localparam int          LAT_W             = 4;

endpackage

// File: rtl/lc3_mem_chan.sv
// One request channel: IDLE -> WAIT -> DONE sequencing, wait-state counter,
// captured read word and the one-cycle completion pulse.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_rd,
    input  logic [DATA_W-1:0] rd_word,
    output logic              sample,
    output logic              complete,
    output logic [DATA_W-1:0] dout
);

    localparam logic [LAT_W-1:0] LAT_M1 = (LAT > 0) ? LAT_W'(LAT - 1) : '0;

    chan_state_t       state;
    chan_state_t       next_state;
    logic [LAT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap_word;
    logic              cap_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A request held through DONE is deliberately not sampled there.
    always_comb begin
        next_state = state;
        sample     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    sample     = 1'b1;
                    next_state = (LAT > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt == '0) next_state = DONE;
            end
            DONE: begin
                complete   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero latency the word goes straight from the array into dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            cap_rd <= 1'b0;
            dout   <= '0;
        end else begin
            if (sample) begin
                cnt    <= LAT_M1;
                cap_rd <= req_rd;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (sample && next_state == DONE && req_rd)
                dout <= rd_word;
            else if (state == WAIT && next_state == DONE && cap_rd)
                dout <= cap_word;
        end
    end

    always_ff @(posedge clk) begin
        if (sample) cap_word <= rd_word;
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Harvard memory responder for the LC3 core: instruction and data arrays, preload port,
// sticky range errors. Define LC3_MEM_STATS_EN to add saturating request counters.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                INSTR_LAT  = 0,
    parameter int                DATA_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     pc,
    input  logic                  instrmem_rd,
    output logic [DATA_W-1:0]     Instr_dout,
    output logic                  complete_instr,
    input  logic [ADDR_W-1:0]     Data_addr,
    input  logic [DATA_W-1:0]     Data_din,
    input  logic                  Data_rd,
    input  logic                  Data_wr,
    output logic [DATA_W-1:0]     Data_dout,
    output logic                  complete_data,
    input  logic                  load_en,
    input  logic                  load_sel,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  instr_err,
    output logic                  data_err
`ifdef LC3_MEM_STATS_EN
    ,
    output logic [31:0]           instr_rd_cnt,
    output logic [31:0]           data_rd_cnt,
    output logic [31:0]           data_wr_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];

    logic [ADDR_W-1:0] instr_idx;
    logic              instr_in_range;
    logic              data_in_range;
    logic [DATA_W-1:0] instr_word;
    logic [DATA_W-1:0] data_word;
    logic              instr_sample;
    logic              data_sample;
    logic              data_req;
    logic              data_conflict;
    logic              data_commit;

    // Instruction index wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land out of range.
    assign instr_idx      = pc - BASE_ADDR;
    assign instr_in_range = (instr_idx >> DEPTH_LOG2) == '0;
    assign instr_word     = instr_in_range ? instr_mem[instr_idx[DEPTH_LOG2-1:0]] : '0;

    assign data_in_range  = (Data_addr >> DEPTH_LOG2) == '0;
    assign data_word      = data_in_range ? data_mem[Data_addr[DEPTH_LOG2-1:0]] : '0;
    assign data_req       = Data_rd | Data_wr;
    assign data_conflict  = Data_rd & Data_wr;
    assign data_commit    = data_sample & Data_wr & ~Data_rd & data_in_range;

    always_ff @(posedge clk) begin
        if (load_en && !load_sel) instr_mem[load_addr] <= load_data;
    end

    // Preload is written last so it wins a same-word collision with a channel write.
    always_ff @(posedge clk) begin
        if (data_commit)          data_mem[Data_addr[DEPTH_LOG2-1:0]] <= Data_din;
        if (load_en && load_sel)  data_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_err <= 1'b0;
            data_err  <= 1'b0;
        end else begin
            if (instr_sample && !instr_in_range)                 instr_err <= 1'b1;
            if (data_sample && (!data_in_range || data_conflict)) data_err  <= 1'b1;
        end
    end

    lc3_mem_chan #(
        .DATA_W (DATA_W),
        .LAT    (INSTR_LAT)
    ) u_instr_chan (
        .clk      (clk),
        .reset    (reset),
        .req      (instrmem_rd),
        .req_rd   (1'b1),
        .rd_word  (instr_word),
        .sample   (instr_sample),
        .complete (complete_instr),
        .dout     (Instr_dout)
    );

    lc3_mem_chan #(
        .DATA_W (DATA_W),
        .LAT    (DATA_LAT)
    ) u_data_chan (
        .clk      (clk),
        .reset    (reset),
        .req      (data_req),
        .req_rd   (Data_rd),
        .rd_word  (data_word),
        .sample   (data_sample),
        .complete (complete_data),
        .dout     (Data_dout)
    );

`ifdef LC3_MEM_STATS_EN
    logic data_last_rd;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            data_last_rd <= 1'b0;
        else if (data_sample) data_last_rd <= Data_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_rd_cnt <= '0;
            data_rd_cnt  <= '0;
            data_wr_cnt  <= '0;
        end else begin
            if (complete_instr)                  instr_rd_cnt <= sat_inc(instr_rd_cnt);
            if (complete_data && data_last_rd)   data_rd_cnt  <= sat_inc(data_rd_cnt);
            if (complete_data && !data_last_rd)  data_wr_cnt  <= sat_inc(data_wr_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (instr/data latency 0/3 and 2/2) driven by
// directed and random requests, checked against a word-level model of both arrays.
module tb_lc3_mem_responder;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc [2];
    logic        instrmem_rd [2];
    logic [15:0] instr_dout [2];
    logic        complete_instr [2];
    logic [15:0] data_addr [2];
    logic [15:0] data_din [2];
    logic        data_rd [2];
    logic        data_wr [2];
    logic [15:0] data_dout [2];
    logic        complete_data [2];
    logic        load_en [2];
    logic        load_sel [2];
    logic [DL-1:0] load_addr [2];
    logic [15:0] load_data [2];
    logic        instr_err [2];
    logic        data_err [2];
`ifdef LC3_MEM_STATS_EN
    logic [31:0] instr_rd_cnt [2];
    logic [31:0] data_rd_cnt [2];
    logic [31:0] data_wr_cnt [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lc3_mem_responder #(
            .INSTR_LAT ((g == 0) ? 0 : 2),
            .DATA_LAT  ((g == 0) ? 3 : 2)
        ) dut (
`ifdef LC3_MEM_STATS_EN
            .instr_rd_cnt   (instr_rd_cnt[g]),
            .data_rd_cnt    (data_rd_cnt[g]),
            .data_wr_cnt    (data_wr_cnt[g]),
`endif
            .clk            (clk),
            .reset          (reset),
            .pc             (pc[g]),
            .instrmem_rd    (instrmem_rd[g]),
            .Instr_dout     (instr_dout[g]),
            .complete_instr (complete_instr[g]),
            .Data_addr      (data_addr[g]),
            .Data_din       (data_din[g]),
            .Data_rd        (data_rd[g]),
            .Data_wr        (data_wr[g]),
            .Data_dout      (data_dout[g]),
            .complete_data  (complete_data[g]),
            .load_en        (load_en[g]),
            .load_sel       (load_sel[g]),
            .load_addr      (load_addr[g]),
            .load_data      (load_data[g]),
            .instr_err      (instr_err[g]),
            .data_err       (data_err[g])
        );
    end

    // Reference model
    logic [15:0] imem_m [2][DEPTH];
    logic [15:0] dmem_m [2][DEPTH];
    logic [15:0] exp_idout [2];
    logic [15:0] exp_ddout [2];
    bit          ierr_m [2];
    bit          derr_m [2];
    int          n_ird [2];
    int          n_drd [2];
    int          n_dwr [2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ilat(input int g);
        return (g == 0) ? 0 : 2;
    endfunction

    function automatic int dlat(input int g);
        return (g == 0) ? 3 : 2;
    endfunction

    function automatic void model_fetch(input int g, input logic [15:0] p);
        logic [15:0] idx;
        idx = p - 16'h3000;
        if (idx < DEPTH) exp_idout[g] = imem_m[g][idx[DL-1:0]];
        else begin
            exp_idout[g] = '0;
            ierr_m[g]    = 1'b1;
        end
        n_ird[g]++;
    endfunction

    function automatic void model_data(input int g, input bit rd, input bit wr,
                                       input logic [15:0] a, input logic [15:0] din);
        bit inr;
        inr = (a < DEPTH);
        if (rd) begin
            exp_ddout[g] = inr ? dmem_m[g][a[DL-1:0]] : '0;
            n_drd[g]++;
        end else begin
            if (inr) dmem_m[g][a[DL-1:0]] = din;
            n_dwr[g]++;
        end
        if (!inr || (rd && wr)) derr_m[g] = 1'b1;
    endfunction

    task automatic fetch(input int g, input logic [15:0] p, input string tag);
        int n = 0;
        model_fetch(g, p);
        pc[g] = p;
        instrmem_rd[g] = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!complete_instr[g] && n < 20);
        check({tag, "/lat"}, n, ilat(g) + 1);
        check({tag, "/dout"}, instr_dout[g], exp_idout[g]);
        check({tag, "/err"}, instr_err[g], ierr_m[g]);
        @(posedge clk); #1;
        check({tag, "/single"}, complete_instr[g], 0);
        check({tag, "/hold"}, instr_dout[g], exp_idout[g]);
        instrmem_rd[g] = 1'b0;
    endtask

    task automatic data_op(input int g, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] din, input bit pl, input logic [DL-1:0] pa,
                           input logic [15:0] pd, input string tag);
        int n = 0;
        model_data(g, rd, wr, a, din);
        if (pl) dmem_m[g][pa] = pd;
        data_addr[g] = a;
        data_din[g]  = din;
        data_rd[g]   = rd;
        data_wr[g]   = wr;
        load_en[g]   = pl;
        load_sel[g]  = 1'b1;
        load_addr[g] = pa;
        load_data[g] = pd;
        do begin
            @(posedge clk); #1;
            load_en[g] = 1'b0;
            n++;
        end while (!complete_data[g] && n < 20);
        check({tag, "/lat"}, n, dlat(g) + 1);
        check({tag, "/dout"}, data_dout[g], exp_ddout[g]);
        check({tag, "/err"}, data_err[g], derr_m[g]);
        @(posedge clk); #1;
        check({tag, "/single"}, complete_data[g], 0);
        check({tag, "/hold"}, data_dout[g], exp_ddout[g]);
        data_rd[g] = 1'b0;
        data_wr[g] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        int          seen;
        int          n;

        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            pc[g] = '0; instrmem_rd[g] = 0; data_addr[g] = '0; data_din[g] = '0;
            data_rd[g] = 0; data_wr[g] = 0; load_en[g] = 0; load_sel[g] = 0;
            load_addr[g] = '0; load_data[g] = '0;
            exp_idout[g] = '0; exp_ddout[g] = '0; ierr_m[g] = 0; derr_m[g] = 0;
            n_ird[g] = 0; n_drd[g] = 0; n_dwr[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("reset/complete_instr", complete_instr[g], 0);
            check("reset/complete_data", complete_data[g], 0);
            check("reset/instr_dout", instr_dout[g], 0);
            check("reset/data_dout", data_dout[g], 0);
            check("reset/errs", {instr_err[g], data_err[g]}, 0);
        end
        reset = 1'b0;

        // Fill every word of both arrays in both instances.
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int g = 0; g < 2; g++) begin
                    v = 16'($urandom);
                    if (sel == 0 && i == 0 && g == 0) v = 16'h1234;
                    load_en[g] = 1'b1; load_sel[g] = sel[0];
                    load_addr[g] = DL'(i); load_data[g] = v;
                    if (sel == 0) imem_m[g][i] = v;
                    else          dmem_m[g][i] = v;
                end
                @(posedge clk); #1;
            end
        end
        for (int g = 0; g < 2; g++) load_en[g] = 1'b0;

        fetch(0, 16'h3000, "fetch0");
        data_op(0, 0, 1, 16'h0005, 16'hBEEF, 0, '0, '0, "wr5");
        data_op(0, 1, 0, 16'h0005, '0, 0, '0, '0, "rd5");
        fetch(0, 16'h3400, "fetch_oor");
        fetch(0, 16'h3000, "fetch_after_oor");
        data_op(0, 0, 1, 16'h0007, 16'hAAAA, 1, 10'd7, 16'h5555, "wr_vs_preload");
        data_op(0, 1, 0, 16'h0007, '0, 0, '0, '0, "rd7");
        data_op(0, 1, 0, 16'h0008, '0, 1, 10'd8, 16'h7777, "rd_vs_preload");
        data_op(0, 1, 0, 16'h0008, '0, 0, '0, '0, "rd8");
        data_op(1, 0, 1, 16'h0400, 16'h1111, 0, '0, '0, "wr_oor");
        data_op(0, 1, 1, 16'h0009, 16'h2222, 0, '0, '0, "rd_and_wr");
        data_op(0, 1, 0, 16'h0009, '0, 0, '0, '0, "rd9");

        // Both channels of the equal-latency instance sampled on one edge.
        model_fetch(1, 16'h3010);
        model_data(1, 1, 0, 16'h0020, '0);
        pc[1] = 16'h3010; instrmem_rd[1] = 1'b1;
        data_addr[1] = 16'h0020; data_rd[1] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!complete_instr[1] && !complete_data[1] && n < 20);
        check("sim/lat", n, 3);
        check("sim/both", {complete_instr[1], complete_data[1]}, 2'b11);
        check("sim/idout", instr_dout[1], exp_idout[1]);
        check("sim/ddout", data_dout[1], exp_ddout[1]);
        @(posedge clk); #1;
        instrmem_rd[1] = 1'b0; data_rd[1] = 1'b0;

        for (int k = 0; k < 40; k++) begin
            int          g;
            int          kind;
            logic [15:0] a;
            g    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                a = ($urandom_range(0, 9) == 0) ? 16'h2FFF : 16'(16'h3000 + $urandom_range(0, 1100));
                fetch(g, a, "rnd_fetch");
            end else begin
                a = 16'($urandom_range(0, 1100));
                data_op(g, kind == 1, kind == 2, a, 16'($urandom), 0, '0, '0, "rnd_data");
            end
        end

        // Reset during the WAIT of a data read abandons it.
        model_data(0, 1, 0, 16'h0005, '0);
        data_addr[0] = 16'h0005; data_rd[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst/complete_data", complete_data[g], 0);
            check("rst/douts", {instr_dout[g], data_dout[g]}, 0);
            check("rst/errs", {instr_err[g], data_err[g]}, 0);
            exp_idout[g] = '0; exp_ddout[g] = '0; ierr_m[g] = 0; derr_m[g] = 0;
            n_ird[g] = 0; n_drd[g] = 0; n_dwr[g] = 0;
        end
        data_rd[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (complete_data[0]) seen++;
        end
        check("rst/no_complete", seen, 0);
        data_op(0, 1, 0, 16'h0005, '0, 0, '0, '0, "rd_after_rst");

        fetch(0, 16'h3000, "st_f1");
        fetch(0, 16'h3001, "st_f2");
        fetch(0, 16'h3002, "st_f3");
        data_op(0, 0, 1, 16'h0010, 16'hCAFE, 0, '0, '0, "st_wr");
        data_op(0, 1, 0, 16'h0010, '0, 0, '0, '0, "st_rd");
        data_op(0, 1, 1, 16'h0011, 16'h0BAD, 0, '0, '0, "st_rdwr");
`ifdef LC3_MEM_STATS_EN
        for (int g = 0; g < 2; g++) begin
            check("stats/instr_rd", instr_rd_cnt[g], n_ird[g]);
            check("stats/data_rd", data_rd_cnt[g], n_drd[g]);
            check("stats/data_wr", data_wr_cnt[g], n_dwr[g]);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
